// File: rtl/fetch_unit.sv
// Instruction-fetch stage: a two-entry buffer holding the word at PC and a
// sequential prefetch of PC+4, filled over a single-outstanding req/ack bus.
// Stall is raised whenever the word at PC is not available this cycle.
module fetch_unit #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32,
  parameter int unsigned CW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] PC,
  output logic [DW-1:0] Instr,
  output logic          InstrValid,
  output logic          Stall,
  output logic          IReq,
  output logic [AW-1:0] IAddr,
  input  logic          IAck,
  input  logic [DW-1:0] IRData,
  output logic [CW-1:0] StallCount
);

  // Addresses are handled as word addresses throughout.
  localparam int unsigned WW = AW - 2;

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StWait = 1'b1;

  logic [1:0]                 valid_q, valid_d;
  logic [1:0][WW-1:0]         addr_q, addr_d;
  logic [1:0][DW-1:0]         data_q, data_d;
  logic [0:0]                 state_q, state_d;
  logic                       ireq_q, ireq_d;
  logic [WW-1:0]              iaddr_q, iaddr_d;
  logic [CW-1:0]              cnt_q, cnt_d;

  logic [WW-1:0] pc_w, pc_nx_w;
  logic [1:0]    hit, nxt, dup;
  logic          ack_ok, bypass, fill_en, fill_idx;

  // Byte offset of PC carries no meaning for a word fetch.
  logic unused_pc_lsb;
  assign unused_pc_lsb = ^PC[1:0];

  assign pc_w    = PC[AW-1:2];
  assign pc_nx_w = pc_w + WW'(1);  // wraps modulo 2^AW
  assign ack_ok  = IAck && (state_q == StWait);
  assign bypass  = ack_ok && (iaddr_q == pc_w);
  assign fill_en = ack_ok && ((iaddr_q == pc_w) || (iaddr_q == pc_nx_w));

  assign IReq       = ireq_q;
  assign IAddr      = {iaddr_q, 2'b00};
  assign StallCount = cnt_q;

  // Per-entry address matches against PC, PC+4 and the returning address.
  always_comb begin
    hit = '0;
    nxt = '0;
    dup = '0;
    for (int i = 0; i < 2; i++) begin
      hit[i] = valid_q[i] && (addr_q[i] == pc_w);
      nxt[i] = valid_q[i] && (addr_q[i] == pc_nx_w);
      dup[i] = valid_q[i] && (addr_q[i] == iaddr_q);
    end
  end

  // Instruction presented to the datapath: response bypass, then buffer hit.
  always_comb begin
    Instr      = '0;
    InstrValid = 1'b0;
    if (bypass) begin
      Instr      = IRData;
      InstrValid = 1'b1;
    end else if (hit[0]) begin
      Instr      = data_q[0];
      InstrValid = 1'b1;
    end else if (hit[1]) begin
      Instr      = data_q[1];
      InstrValid = 1'b1;
    end
    Stall = ~InstrValid;
  end

  // Fill target: existing copy, else a free entry, else the entry holding
  // neither PC nor PC+4 (always exists since the requested word was absent).
  always_comb begin
    fill_idx = 1'b1;
    if (dup[0]) begin
      fill_idx = 1'b0;
    end else if (dup[1]) begin
      fill_idx = 1'b1;
    end else if (!valid_q[0]) begin
      fill_idx = 1'b0;
    end else if (!valid_q[1]) begin
      fill_idx = 1'b1;
    end else if (!hit[0] && !nxt[0]) begin
      fill_idx = 1'b0;
    end
  end

  // Buffer next state; responses for addresses other than PC/PC+4 are dropped.
  always_comb begin
    valid_d = valid_q;
    addr_d  = addr_q;
    data_d  = data_q;
    if (fill_en) begin
      valid_d[fill_idx] = 1'b1;
      addr_d[fill_idx]  = iaddr_q;
      data_d[fill_idx]  = IRData;
    end
  end

  // Request FSM: demand fetch first, then prefetch, one request in flight.
  always_comb begin
    state_d = state_q;
    ireq_d  = ireq_q;
    iaddr_d = iaddr_q;
    case (state_q)
      StIdle: begin
        if (!(|hit)) begin
          ireq_d  = 1'b1;
          iaddr_d = pc_w;
          state_d = StWait;
        end else if (!(|nxt)) begin
          ireq_d  = 1'b1;
          iaddr_d = pc_nx_w;
          state_d = StWait;
        end
      end
      StWait: begin
        if (IAck) begin
          ireq_d  = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Saturating count of stalled cycles.
  always_comb begin
    cnt_d = cnt_q;
    if (Stall && (cnt_q != {CW{1'b1}})) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      state_q <= StIdle;
      ireq_q  <= 1'b0;
      iaddr_q <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      state_q <= state_d;
      ireq_q  <= ireq_d;
      iaddr_q <= iaddr_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
